// File: rtl/fp_std_0.sv
// fp_std_0 - front-end stage of the 24-bit float add/sub/max/min unit.
//
// This stage unpacks two operands and orders them by magnitude. It aligns
// the smaller mantissa to the larger one and forms the raw sum and
// difference mantissas. It also selects the numeric max/min operands.
// The normalise/pack stage downstream consumes these results.
//
// Float format: sign[23], exponent[22:15] (bias 127), mantissa[14:0].
// The hidden bit is (exponent != 0). Denormals, NaN and Inf get no
// special handling.
//
// Pipeline: two registered stages, with valid travelling alongside data.
// A global stall holds every stage register.
//
// Ports
//   clk_i                  clock
//   rst_i                  asynchronous active-high reset
//   valid_i                operand pair present
//   ready_o                = !stall_i; a pair is accepted on valid_i & ready_o
//   stall_i                hold all pipeline registers
//   op_i[3:0]              [1:0] 00 add/sub, 01 max, 10 min, 11 reserved;
//                          [2] subtract (invert B sign); [3] passed through
//   a_i, b_i               operands
//   valid_o                outputs below are valid
//   op_o                   op_i delayed by two accepted cycles
//   max_sign_o/min_sign_o  sign of larger/smaller magnitude operand
//                          (after subtract inversion)
//   max_exponent_o         exponent of larger magnitude operand
//   add_result_mantissa_o  raw magnitude sum (17 bits)
//   sub_result_mantissa_o  raw magnitude difference (16 bits)
//   max_result_o/min_result_o  numeric max/min of a_i, b_i (original signs)
module fp_std_0 #(
  parameter int WIDTH = 24
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic             stall_i,
  input  logic [3:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             valid_o,
  output logic [3:0]       op_o,
  output logic             max_sign_o,
  output logic             min_sign_o,
  output logic [7:0]       max_exponent_o,
  output logic [16:0]      add_result_mantissa_o,
  output logic [15:0]      sub_result_mantissa_o,
  output logic [WIDTH-1:0] max_result_o,
  output logic [WIDTH-1:0] min_result_o
);

  // {hidden, mantissa}; a zero exponent contributes a zero hidden bit
  function automatic logic [15:0] unpack_mant(input logic [23:0] x);
    return {|x[22:15], x[14:0]};
  endfunction

  // Right shift for alignment; shifts of 16 or more flush to zero and
  // shifted-out bits are dropped (no guard/sticky)
  function automatic logic [15:0] align_mant(input logic [15:0] m,
                                             input logic [7:0]  sh);
    logic [15:0] r;
    if (sh >= 8'd16) r = 16'd0;
    else             r = m >> sh[3:0];
    return r;
  endfunction

  // True when A is the numeric maximum. The +0 operand beats -0 because
  // the signs differ. Exact equality resolves to A.
  function automatic logic a_is_max(input logic [23:0] a, input logic [23:0] b);
    logic r;
    if (a == b)              r = 1'b1;
    else if (a[23] != b[23]) r = ~a[23];
    else if (!a[23])         r = (a[22:0] > b[22:0]);
    else                     r = (a[22:0] < b[22:0]);
    return r;
  endfunction

  assign ready_o = ~stall_i;

  logic       b_sign_eff_p0;
  logic       a_big_p0;
  logic       a_max_p0;
  logic       accept_p0;

  // Subtract inversion applies to add/sub only; max/min keep B's sign
  assign b_sign_eff_p0 = b_i[23] ^ ((op_i[1:0] == 2'b00) & op_i[2]);
  // {exp,mant} compares as an unsigned magnitude; a tie keeps A as big
  assign a_big_p0      = (a_i[22:0] >= b_i[22:0]);
  assign a_max_p0      = a_is_max(a_i[23:0], b_i[23:0]);
  assign accept_p0     = valid_i & ~stall_i;

  // ---- stage 1: operand ordering and exponent difference ----
  logic        vld_p1;
  logic        big_sign_p1;
  logic        small_sign_p1;
  logic [7:0]  big_exp_p1;
  logic [7:0]  diff_p1;
  logic [15:0] big_m_p1;
  logic [15:0] small_m_p1;
  logic [23:0] max_p1;
  logic [23:0] min_p1;
  logic [3:0]  op_p1;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)         vld_p1 <= 1'b0;
    else if (!stall_i) vld_p1 <= valid_i;
  end

  // Data loads only on accept, so an empty stage leaves it untouched
  always_ff @(posedge clk_i) begin
    if (accept_p0) begin
      op_p1 <= op_i;
      if (a_big_p0) begin
        big_sign_p1   <= a_i[23];
        small_sign_p1 <= b_sign_eff_p0;
        big_exp_p1    <= a_i[22:15];
        diff_p1       <= a_i[22:15] - b_i[22:15];
        big_m_p1      <= unpack_mant(a_i[23:0]);
        small_m_p1    <= unpack_mant(b_i[23:0]);
      end else begin
        big_sign_p1   <= b_sign_eff_p0;
        small_sign_p1 <= a_i[23];
        big_exp_p1    <= b_i[22:15];
        diff_p1       <= b_i[22:15] - a_i[22:15];
        big_m_p1      <= unpack_mant(b_i[23:0]);
        small_m_p1    <= unpack_mant(a_i[23:0]);
      end
      max_p1 <= a_max_p0 ? a_i[23:0] : b_i[23:0];
      min_p1 <= a_max_p0 ? b_i[23:0] : a_i[23:0];
    end
  end

  logic [15:0] aligned_p1;
  assign aligned_p1 = align_mant(small_m_p1, diff_p1);

  // ---- stage 2: alignment and raw sum/difference ----
  // The outputs reset to zero and load only when stage 1 holds valid
  // data. They therefore stay zero after reset until a new pair arrives.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_o               <= 1'b0;
      op_o                  <= 4'd0;
      max_sign_o            <= 1'b0;
      min_sign_o            <= 1'b0;
      max_exponent_o        <= 8'd0;
      add_result_mantissa_o <= 17'd0;
      sub_result_mantissa_o <= 16'd0;
      max_result_o          <= '0;
      min_result_o          <= '0;
    end else if (!stall_i) begin
      valid_o <= vld_p1;
      if (vld_p1) begin
        op_o                  <= op_p1;
        max_sign_o            <= big_sign_p1;
        min_sign_o            <= small_sign_p1;
        max_exponent_o        <= big_exp_p1;
        add_result_mantissa_o <= {1'b0, big_m_p1} + {1'b0, aligned_p1};
        // big magnitude >= aligned small magnitude, so this cannot wrap
        sub_result_mantissa_o <= big_m_p1 - aligned_p1;
        max_result_o          <= max_p1;
        min_result_o          <= min_p1;
      end
    end
  end

endmodule

// File: tb/tb_fp_std_0.sv
module tb_fp_std_0;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        valid = 1'b0;
  logic        stall = 1'b0;
  logic [3:0]  op = 4'd0;
  logic [23:0] a = 24'd0;
  logic [23:0] b = 24'd0;
  logic        ready_o;
  logic        valid_o;
  logic [3:0]  op_o;
  logic        max_sign_o;
  logic        min_sign_o;
  logic [7:0]  max_exponent_o;
  logic [16:0] add_result_mantissa_o;
  logic [15:0] sub_result_mantissa_o;
  logic [23:0] max_result_o;
  logic [23:0] min_result_o;

  fp_std_0 #(.WIDTH(24)) dut (
    .clk_i                 (clk),
    .rst_i                 (rst),
    .valid_i               (valid),
    .ready_o               (ready_o),
    .stall_i               (stall),
    .op_i                  (op),
    .a_i                   (a),
    .b_i                   (b),
    .valid_o               (valid_o),
    .op_o                  (op_o),
    .max_sign_o            (max_sign_o),
    .min_sign_o            (min_sign_o),
    .max_exponent_o        (max_exponent_o),
    .add_result_mantissa_o (add_result_mantissa_o),
    .sub_result_mantissa_o (sub_result_mantissa_o),
    .max_result_o          (max_result_o),
    .min_result_o          (min_result_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  op;
    logic        ms;
    logic        ns;
    logic [7:0]  me;
    logic [16:0] add;
    logic [15:0] sub;
    logic [23:0] mx;
    logic [23:0] mn;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  bit   last_stall = 1'b0;

  // Reference model: works on integer magnitudes and signed numeric keys
  function automatic exp_t model(input logic [23:0] aa, input logic [23:0] bb,
                                 input logic [3:0] oo);
    exp_t r;
    int ma, mb, ea, eb, va, vb, bm, sm, d, al, ka, kb;
    bit sbe, abig;
    ma = int'(aa[22:0]);
    mb = int'(bb[22:0]);
    ea = int'(aa[22:15]);
    eb = int'(bb[22:15]);
    va = (ea != 0 ? 32768 : 0) + int'(aa[14:0]);
    vb = (eb != 0 ? 32768 : 0) + int'(bb[14:0]);
    sbe = bb[23] ^ ((oo[1:0] == 2'b00) && oo[2]);
    abig = (ma >= mb);
    bm = abig ? va : vb;
    sm = abig ? vb : va;
    d  = abig ? ea - eb : eb - ea;
    al = (d >= 16) ? 0 : sm / (1 << d);
    r.op  = oo;
    r.ms  = abig ? aa[23] : sbe;
    r.ns  = abig ? sbe : aa[23];
    r.me  = abig ? aa[22:15] : bb[22:15];
    r.add = 17'(bm + al);
    r.sub = 16'(bm - al);
    ka = aa[23] ? -ma : ma;
    kb = bb[23] ? -mb : mb;
    if (aa == bb) begin
      r.mx = aa; r.mn = aa;
    end else if (ka > kb || (ka == kb && !aa[23])) begin
      r.mx = aa; r.mn = bb;
    end else begin
      r.mx = bb; r.mn = aa;
    end
    return r;
  endfunction

  function automatic exp_t observed();
    exp_t r;
    r.op  = op_o;
    r.ms  = max_sign_o;
    r.ns  = min_sign_o;
    r.me  = max_exponent_o;
    r.add = add_result_mantissa_o;
    r.sub = sub_result_mantissa_o;
    r.mx  = max_result_o;
    r.mn  = min_result_o;
    return r;
  endfunction

  function automatic logic [23:0] rand_operand(input logic [23:0] other);
    logic [23:0] x;
    case ($urandom_range(0, 5))
      0:       x = other;
      1:       x = other ^ 24'h800000;
      2:       x = {other[23:15] ^ 9'(1 << $urandom_range(0, 4)), 15'($urandom)};
      3:       x = {1'($urandom), 8'd0, 15'($urandom)};
      default: x = 24'($urandom);
    endcase
    return x;
  endfunction

  // Drives one cycle of inputs and records accepted pairs in the queue
  task automatic drive(input bit v, input logic [23:0] aa, input logic [23:0] bb,
                       input logic [3:0] oo, input bit st);
    valid = v; a = aa; b = bb; op = oo; stall = st;
    if (v && !st) q.push_back(model(aa, bb, oo));
    @(posedge clk); #1;
    last_stall = st;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    valid = 1'b1; a = 24'h3F8000; b = 24'h3F8000; op = 4'd0; stall = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (valid_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_valid: got %b expected 0", valid_o);
    end
    n_checks++;
    if (observed() !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got %h expected 0", observed());
    end
    n_checks++;
    if (ready_o !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready: got %b expected 1", ready_o);
    end
    valid = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic [23:0] ta[7];
    logic [23:0] tb[7];
    exp_t        te[7];
    ta[0] = 24'h3F8000; tb[0] = 24'h3F8000;
    te[0] = '{4'h0, 1'b0, 1'b0, 8'h7F, 17'h10000, 16'h0000, 24'h3F8000, 24'h3F8000};
    ta[1] = 24'h3F8000; tb[1] = 24'h400000;
    te[1] = '{4'h0, 1'b0, 1'b0, 8'h80, 17'h0C000, 16'h4000, 24'h400000, 24'h3F8000};
    ta[2] = 24'h400000; tb[2] = 24'h3F8000;
    te[2] = '{4'h4, 1'b0, 1'b1, 8'h80, 17'h0C000, 16'h4000, 24'h400000, 24'h3F8000};
    ta[3] = 24'hBF8000; tb[3] = 24'h3F0000;
    te[3] = '{4'h1, 1'b1, 1'b0, 8'h7F, 17'h0C000, 16'h4000, 24'h3F0000, 24'hBF8000};
    ta[4] = 24'hBF8000; tb[4] = 24'h3F0000;
    te[4] = '{4'h2, 1'b1, 1'b0, 8'h7F, 17'h0C000, 16'h4000, 24'h3F0000, 24'hBF8000};
    ta[5] = 24'h000000; tb[5] = 24'h800000;
    te[5] = '{4'h1, 1'b0, 1'b1, 8'h00, 17'h00000, 16'h0000, 24'h000000, 24'h800000};
    ta[6] = 24'h498000; tb[6] = 24'h3F8000;
    te[6] = '{4'h0, 1'b0, 1'b0, 8'h93, 17'h08000, 16'h8000, 24'h498000, 24'h3F8000};
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, ta[i], tb[i], te[i].op, 1'b0);
      n_checks++;
      if (valid_o !== 1'b0) begin
        n_fail++; $display("FAIL directed_%0d_early_valid: got %b expected 0", i, valid_o);
      end
      drive(1'b0, 24'd0, 24'd0, 4'd0, 1'b0);
      n_checks++;
      if (valid_o !== 1'b1) begin
        n_fail++; $display("FAIL directed_%0d_valid: got %b expected 1", i, valid_o);
      end
      n_checks++;
      if (observed() !== te[i]) begin
        n_fail++; $display("FAIL directed_%0d_fields: got %h expected %h", i, observed(), te[i]);
      end
    end
    q.delete();
  endtask

  task automatic test_random();
    logic [23:0] ra, rb;
    exp_t e;
    for (int i = 0; i < 120; i++) begin
      ra = 24'($urandom);
      rb = rand_operand(ra);
      if (i < 110) drive($urandom_range(0, 3) != 0, ra, rb, 4'($urandom), $urandom_range(0, 4) == 0);
      else         drive(1'b0, ra, rb, 4'd0, 1'b0);
      if (valid_o && !last_stall) begin
        n_checks++;
        if (q.size() == 0) begin
          n_fail++; $display("FAIL random_%0d_unexpected: got valid_o 1 expected no output", i);
        end else begin
          e = q.pop_front();
          if (observed() !== e) begin
            n_fail++; $display("FAIL random_%0d: got %h expected %h", i, observed(), e);
          end
        end
      end
    end
    n_checks++;
    if (q.size() != 0) begin
      n_fail++; $display("FAIL random_drain: got %0d pending expected 0", q.size());
      q.delete();
    end
  endtask

  task automatic test_back_to_back();
    logic [23:0] sa[4];
    logic [23:0] sb[4];
    logic [3:0]  so[4];
    int   idx, popped;
    bit   st, v;
    exp_t e, prev;
    sa[0] = 24'h3F8000; sb[0] = 24'h400000; so[0] = 4'h0;
    sa[1] = 24'h400000; sb[1] = 24'h3F8000; so[1] = 4'h4;
    sa[2] = 24'hBF8000; sb[2] = 24'h3F0000; so[2] = 4'h1;
    sa[3] = 24'h498000; sb[3] = 24'h3F8000; so[3] = 4'hA;
    idx = 0; popped = 0;
    prev = observed();
    for (int c = 0; c < 12; c++) begin
      st = (c >= 2 && c <= 4);
      v  = (idx < 4);
      drive(v, v ? sa[idx] : 24'd0, v ? sb[idx] : 24'd0, v ? so[idx] : 4'd0, st);
      if (v && !st) idx++;
      n_checks++;
      if (ready_o !== !st) begin
        n_fail++; $display("FAIL b2b_%0d_ready: got %b expected %b", c, ready_o, !st);
      end
      if (last_stall) begin
        n_checks++;
        if (observed() !== prev || valid_o !== (c > 1)) begin
          n_fail++; $display("FAIL b2b_%0d_hold: got %h expected %h", c, observed(), prev);
        end
      end else if (valid_o) begin
        n_checks++;
        if (q.size() == 0) begin
          n_fail++; $display("FAIL b2b_%0d_extra: got valid_o 1 expected no output", c);
        end else begin
          e = q.pop_front();
          popped++;
          if (observed() !== e) begin
            n_fail++; $display("FAIL b2b_%0d: got %h expected %h", c, observed(), e);
          end
        end
      end
      prev = observed();
    end
    n_checks++;
    if (popped != 4 || q.size() != 0) begin
      n_fail++; $display("FAIL b2b_count: got %0d outputs expected 4", popped);
    end
    q.delete();

    // Reset with two pairs in flight, stall asserted alongside
    drive(1'b1, sa[0], sb[0], so[0], 1'b0);
    drive(1'b1, sa[1], sb[1], so[1], 1'b0);
    #2;
    rst = 1'b1;
    stall = 1'b1;
    #1;
    n_checks++;
    if (valid_o !== 1'b0 || observed() !== '0) begin
      n_fail++; $display("FAIL async_reset: got valid %b data %h expected 0", valid_o, observed());
    end
    @(posedge clk); #1;
    rst = 1'b0;
    q.delete();
    for (int c = 0; c < 3; c++) begin
      drive(1'b0, 24'hFFFFFF, 24'hFFFFFF, 4'hF, 1'b0);
      n_checks++;
      if (valid_o !== 1'b0 || observed() !== '0) begin
        n_fail++; $display("FAIL post_reset_%0d: got valid %b data %h expected 0", c, valid_o, observed());
      end
    end
    drive(1'b1, sa[2], sb[2], so[2], 1'b0);
    drive(1'b0, 24'd0, 24'd0, 4'd0, 1'b0);
    n_checks++;
    if (valid_o !== 1'b1 || q.size() != 1) begin
      n_fail++; $display("FAIL post_reset_accept: got valid %b expected 1", valid_o);
    end else begin
      e = q.pop_front();
      n_checks++;
      if (observed() !== e) begin
        n_fail++; $display("FAIL post_reset_data: got %h expected %h", observed(), e);
      end
    end
    q.delete();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
